class_score_acc: RTL

CLASS_SCORE_ACC -- requirements
Module: class_score_acc

---
 rtl/class_score_pkg.sv | 14 +
 rtl/score_sat.sv | 33 +++
 rtl/class_score_acc.sv | 117 +++++++++++
 3 files changed

// File: rtl/class_score_pkg.sv
// Shared widths and types for the class score accumulator.
package class_score_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 8;
    localparam int PROD_W      = 16;
    localparam int ACC_W       = 24;
    localparam int SHIFT       = 4;

    // One byte per class.
    // Class i occupies bits [i*8+7:i*8].
    typedef logic [NUM_CLASSES*SCORE_W-1:0] score_array_t;

endpackage

// File: rtl/score_sat.sv
// Shift-and-clamp stage.
// Scales a class sum down by SHIFT and limits it to an unsigned byte score.
// The clamped output reports that the result was forced to 0 or to 255.
module score_sat
    import class_score_pkg::*;
#(
    parameter int ACC_W = class_score_pkg::ACC_W,
    parameter int SHIFT = class_score_pkg::SHIFT
) (
    input  logic signed [ACC_W-1:0]   sum,
    output logic        [SCORE_W-1:0] score,
    output logic                      clamped
);

    logic signed [ACC_W-1:0] shifted;

    assign shifted = sum >>> SHIFT;

    // The sign bit flags a negative value.
    // Any set bit above the score byte means the value exceeds 255.
    always_comb begin
        score   = shifted[SCORE_W-1:0];
        clamped = 1'b0;
        if (shifted[ACC_W-1]) begin
            score   = '0;
            clamped = 1'b1;
        end else if (|shifted[ACC_W-2:SCORE_W]) begin
            score   = '1;
            clamped = 1'b1;
        end
    end

endmodule

// File: rtl/class_score_acc.sv
// Class score accumulator.
// Sums signed partial products per class and scales each class sum to a byte.
// It then assembles NUM_CLASSES scores into one frame for the argmax stage.
// Optional feature: define CLASS_SCORE_SAT_FLAG_EN to add the sat_flag output.
// sat_flag is set by any clamp within the frame.
module class_score_acc
    import class_score_pkg::*;
#(
    parameter int NUM_CLASSES = class_score_pkg::NUM_CLASSES,
    parameter int PROD_W      = class_score_pkg::PROD_W,
    parameter int ACC_W       = class_score_pkg::ACC_W,
    parameter int SHIFT       = class_score_pkg::SHIFT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic signed [PROD_W-1:0]        in_data,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
`ifdef CLASS_SCORE_SAT_FLAG_EN
    output logic                            sat_flag,
`endif
    output logic [SCORE_W*NUM_CLASSES-1:0]  array
);

    localparam int                CNT_W      = $clog2(NUM_CLASSES);
    localparam logic [CNT_W-1:0]  LAST_CLASS = CNT_W'(NUM_CLASSES - 1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic [CNT_W-1:0]        class_cnt;
    logic                    accept;
    logic                    handshake;
    logic                    frame_done;
    logic [SCORE_W-1:0]      score;
    logic                    clamped;

    // A held frame blocks new beats unless it leaves on this same edge.
    // This lets the first beat of the next frame overlap the handshake.
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign handshake  = out_valid && out_ready;
    assign frame_done = accept && in_last && (class_cnt == LAST_CLASS);

    // The sum includes the current beat.
    // This lets a last beat, including a single-beat class, be scored in the same cycle.
    assign sum = acc + {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};

    score_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_score_sat (
        .sum     (sum),
        .score   (score),
        .clamped (clamped)
    );

    // Accumulate beats.
    // On a class's last beat, restart the sum and move to the next slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            class_cnt <= '0;
        end else if (accept) begin
            if (in_last) begin
                acc       <= '0;
                class_cnt <= (class_cnt == LAST_CLASS) ? '0 : class_cnt + 1'b1;
            end else begin
                acc <= sum;
            end
        end
    end

    // Write only the slot of the class that just completed.
    // The other slots keep their previous scores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            array <= '0;
        end else if (accept && in_last) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (class_cnt == CNT_W'(i)) begin
                    array[i*SCORE_W +: SCORE_W] <= score;
                end
            end
        end
    end

    // Present a frame the cycle after its final slot is written.
    // Hold the frame until it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (frame_done) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef CLASS_SCORE_SAT_FLAG_EN
    // Record any clamp in the frame being built.
    // A clamp on the handshake edge belongs to the next frame, so it survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else begin
            sat_flag <= (sat_flag && !handshake) || (accept && in_last && clamped);
        end
    end
`else
    logic unused_clamp_info;
    assign unused_clamp_info = clamped ^ handshake;
`endif

endmodule
